// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Two-requester round-robin arbiter feeding a shared UART
//               transmitter, with one-entry holding slots and busy timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic                  tx_strobe_start,
  input  logic                  tx_strobe_busy,
  output logic                  grant_id,
  output logic                  arb_busy,
  output logic                  timeout_err
);

  localparam int c_CNT_W = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_START     = 2'd1;
  localparam logic [1:0] c_WAIT_BUSY = 2'd2;
  localparam logic [1:0] c_WAIT_DONE = 2'd3;

  logic [1:0]            r_state;
  logic                  r_pend0;
  logic                  r_pend1;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_grant;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_timeout;

  logic w_grant;
  logic w_pick1;

  // On a tie the requester that did not win last time goes next.
  assign w_grant = (r_state == c_IDLE) && (r_pend0 || r_pend1);
  assign w_pick1 = r_pend1 && (!r_pend0 || !r_grant);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_pend0   <= 1'b0;
      r_pend1   <= 1'b0;
      r_data0   <= '0;
      r_data1   <= '0;
      r_tx_data <= '0;
      r_grant   <= 1'b1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Holding slots: a grant empties the winner, an empty slot takes a byte.
      if (w_grant && !w_pick1) begin
        r_pend0 <= 1'b0;
      end else if (req0_valid && !r_pend0) begin
        r_pend0 <= 1'b1;
        r_data0 <= req0_data;
      end

      if (w_grant && w_pick1) begin
        r_pend1 <= 1'b0;
      end else if (req1_valid && !r_pend1) begin
        r_pend1 <= 1'b1;
        r_data1 <= req1_data;
      end

      case (r_state)
        c_IDLE: begin
          if (w_grant) begin
            r_tx_data <= w_pick1 ? r_data1 : r_data0;
            r_grant   <= w_pick1;
            r_state   <= c_START;
          end
        end
        c_START: begin
          r_cnt   <= '0;
          r_state <= c_WAIT_BUSY;
        end
        c_WAIT_BUSY: begin
          if (tx_strobe_busy) begin
            r_state <= c_WAIT_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_WAIT_DONE: begin
          if (!tx_strobe_busy) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign req0_ready      = !r_pend0;
  assign req1_ready      = !r_pend1;
  assign tx_data_out     = r_tx_data;
  assign tx_strobe_start = (r_state == c_START);
  assign grant_id        = r_grant;
  assign arb_busy        = (r_state != c_IDLE);
  assign timeout_err     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a
//               transaction-level expectation queue and transmitter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int BT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] tx_data_out;
  logic          tx_strobe_start;
  logic          tx_strobe_busy;
  logic          grant_id;
  logic          arb_busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .tx_data_out    (tx_data_out),
    .tx_strobe_start(tx_strobe_start),
    .tx_strobe_busy (tx_strobe_busy),
    .grant_id       (grant_id),
    .arb_busy       (arb_busy),
    .timeout_err    (timeout_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected transfers in order: {grant_id, byte}.
  logic [DW:0] exp_q[$];
  logic [DW:0] r_exp;
  logic        prev_busy   = 1'b0;
  logic        prev_strobe = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int          nstrobes = 0;
  bit          xmit_en  = 1'b1;
  int          busy_len = 20;

  // Transmitter: busy rises one cycle after the strobe and lasts busy_len cycles.
  initial begin
    tx_strobe_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && tx_strobe_start && xmit_en) begin
        @(posedge clk);
        #1 tx_strobe_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_strobe_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (tx_strobe_start) begin
        nstrobes++;
        chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
        chk("busy_low_at_strobe", {31'd0, tx_strobe_busy}, 32'd0);
        chk("ready_after_grant", {31'd0, grant_id ? req1_ready : req0_ready}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          r_exp = exp_q.pop_front();
          chk("strobe_data", {24'd0, tx_data_out}, {24'd0, r_exp[DW-1:0]});
          chk("strobe_grant", {31'd0, grant_id}, {31'd0, r_exp[DW]});
        end
      end
      if (arb_busy && prev_busy)
        chk("hold_stable", {24'd0, tx_data_out}, {24'd0, prev_data});
      prev_busy   = arb_busy;
      prev_strobe = tx_strobe_start;
      prev_data   = tx_data_out;
    end else begin
      prev_busy   = 1'b0;
      prev_strobe = 1'b0;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd1);
    chk("rst_data", {24'd0, tx_data_out}, 32'd0);
    chk("rst_strobe", {31'd0, tx_strobe_start}, 32'd0);
    chk("rst_grant", {31'd0, grant_id}, 32'd1);
    chk("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
  endtask

  // All tasks below start and end at #1 after a rising edge.
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic send(input bit which, input logic [DW-1:0] d);
    int n = 0;
    while (!(which ? req1_ready : req0_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("send_ready_timeout", 32'd1, 32'd0);
    if (which) begin req1_valid = 1'b1; req1_data = d; end
    else       begin req0_valid = 1'b1; req0_data = d; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(!arb_busy && req0_ready && req1_ready && !tx_strobe_busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0;    req1_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b1;

    // Single byte with latency: accepted at edge E, strobe after E+1.
    exp_q.push_back({1'b0, 8'hA5});
    req0_valid = 1'b1; req0_data = 8'hA5;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("lat_ready0_full", {31'd0, req0_ready}, 32'd0);
    chk("lat_no_strobe_yet", {31'd0, tx_strobe_start}, 32'd0);
    @(posedge clk); #1;
    chk("lat_strobe", {31'd0, tx_strobe_start}, 32'd1);
    chk("single_data", {24'd0, tx_data_out}, 32'hA5);
    chk("single_grant", {31'd0, grant_id}, 32'd0);
    chk("single_arb_busy", {31'd0, arb_busy}, 32'd1);
    chk("single_ready0_again", {31'd0, req0_ready}, 32'd1);
    wait_idle();
    chk("single_arb_idle", {31'd0, arb_busy}, 32'd0);
    chk("single_data_held", {24'd0, tx_data_out}, 32'hA5);

    // Contention after reset: req0 wins the first tie, then alternation.
    do_reset();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'hEE});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'hDD});
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'hEE;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_ready0_full", {31'd0, req0_ready}, 32'd0);
    chk("cont_ready1_full", {31'd0, req1_ready}, 32'd0);
    n = 0;
    while (!(req0_ready && req1_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("cont_refill_timeout", 32'd1, 32'd0);
    chk("cont_grant_before_refill", {31'd0, grant_id}, 32'd1);
    req0_valid = 1'b1; req0_data = 8'h22;
    req1_valid = 1'b1; req1_data = 8'hDD;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Back-to-back from req1.
    exp_q.push_back({1'b1, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    exp_q.push_back({1'b1, 8'h03});
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    send(1'b1, 8'h03);
    wait_idle();
    chk("b2b_queue_drained", exp_q.size(), 32'd0);

    // Timeout: transmitter never answers.
    xmit_en = 1'b0;
    exp_q.push_back({1'b0, 8'h55});
    send(1'b0, 8'h55);
    n = 0;
    while (!tx_strobe_start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_strobe_latency", n, 32'd1);
    repeat (BT) @(posedge clk);
    #1;
    chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
    chk("to_still_waiting", {31'd0, arb_busy}, 32'd1);
    @(posedge clk); #1;
    chk("to_flag", {31'd0, timeout_err}, 32'd1);
    chk("to_back_idle", {31'd0, arb_busy}, 32'd0);
    xmit_en = 1'b1;
    exp_q.push_back({1'b1, 8'h77});
    send(1'b1, 8'h77);
    wait_idle();
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset during WAIT_DONE with a byte pending in slot 1.
    exp_q.push_back({1'b0, 8'hA1});
    send(1'b0, 8'hA1);
    n = 0;
    while (!tx_strobe_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("mid_busy_timeout", 32'd1, 32'd0);
    send(1'b1, 8'hB2);
    chk("mid_pend1_set", {31'd0, req1_ready}, 32'd0);
    chk("mid_arb_busy", {31'd0, arb_busy}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals();
    reset = 1'b1;
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tx_strobe_start) n++;
    end
    chk("mid_no_strobe_after_release", n, 32'd0);

    chk("strobe_total", nstrobes, 32'd11);
    chk("queue_empty_at_end", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of all data paths.
REQ-002 Parameter BUSY_TIMEOUT, default 16, cycles allowed for the transmitter to raise busy after a start strobe.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 req0_valid  input  1  CPU requester offers a byte.
REQ-006 req0_data  input  DATA_WIDTH  CPU byte.
REQ-007 req0_ready  output  1  CPU holding slot empty; byte accepted when valid and ready are both 1 at a rising edge.
REQ-008 req1_valid  input  1  system requester (error/status reporter) offers a byte.
REQ-009 req1_data  input  DATA_WIDTH  system byte.
REQ-010 req1_ready  output  1  system holding slot empty; same handshake as req0.
REQ-011 tx_data_out  output  DATA_WIDTH  byte presented to the shared uart_transmitter tx_parallel_data_in.
REQ-012 tx_strobe_start  output  1  one-cycle start pulse to the transmitter.
REQ-013 tx_strobe_busy  input  1  transmitter busy flag.
REQ-014 grant_id  output  1  requester index of the most recent grant.
REQ-015 arb_busy  output  1  high in every state except IDLE.
REQ-016 timeout_err  output  1  sticky flag: a start strobe was not acknowledged by busy.

Function
REQ-017 Each requester owns a one-entry holding slot (pend flag + data register); reqN_ready = !pendN.
REQ-018 On valid&ready at a rising edge, the data is captured and pendN is set at that edge.
REQ-019 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE: if any pend is set, select a winner, copy its data to the tx_data register, clear its pend, set grant_id, and go to START; otherwise stay.
REQ-021 Arbitration: if only one pend is set, it wins; if both are set, the requester != grant_id wins (round-robin); after reset, req0 wins a tie.
REQ-022 START: tx_strobe_start = 1 for exactly this one cycle; go to WAIT_BUSY and clear the timeout counter.
REQ-023 WAIT_BUSY: if tx_strobe_busy = 1, go to WAIT_DONE; otherwise increment the counter; when the counter reaches BUSY_TIMEOUT-1 without busy, set timeout_err, drop the byte, and go to IDLE.
REQ-024 WAIT_DONE: stay while tx_strobe_busy = 1; on busy = 0, go to IDLE.
REQ-025 Latency: a byte accepted at edge E with the FSM in IDLE and the other slot empty produces tx_strobe_start high during the cycle after edge E+1.
REQ-026 tx_data_out is stable from entry to START until the next grant; it never changes while arb_busy = 1.
REQ-027 A slot cleared at grant accepts a new byte on the next edge, while the previous byte is still transmitting.
REQ-028 A requester's valid held high while its slot is full has no effect; no byte is lost or duplicated.
REQ-029 timeout_err clears only on reset.
REQ-030 Counter width: clog2(BUSY_TIMEOUT)+1 bits; no wrap-around is possible before the timeout fires.

Reset
REQ-031 While reset = 0 at a rising edge:
- state = IDLE
- pend0 = pend1 = 0
- tx_data_out = 0, tx_strobe_start = 0
- grant_id = 1 (so req0 wins the first tie), arb_busy = 0, timeout_err = 0
- counter = 0
REQ-032 Reset asserted mid-transmission aborts immediately; pending bytes are discarded; no strobe is issued in the cycle following release.

Verification
REQ-033 Single byte: req0 sends 8'hA5 with a transmitter model that raises busy 1 cycle after the strobe for 20 cycles -> one strobe, tx_data_out = 8'hA5, grant_id = 0, arb_busy returns to 0.
REQ-034 Contention: req0 = 8'h11 and req1 = 8'hEE are accepted on the same edge after reset -> strobes carry 8'h11 then 8'hEE; next tie with both slots refilled grants req0 again (alternation).
REQ-035 Back-to-back: req1 posts 8'h01, 8'h02, 8'h03 as soon as ready -> exactly three strobes in order, each only after busy has fallen; ready is high again one edge after each grant.
REQ-036 Timeout: transmitter model never raises busy; req0 sends 8'h55 -> after BUSY_TIMEOUT cycles in WAIT_BUSY, timeout_err = 1, FSM returns to IDLE, and a subsequent req1 byte is still serviced.
REQ-037 Reset mid-operation: reset = 0 during WAIT_DONE with pend1 set -> all outputs return to reset values, and no strobe is issued for the discarded byte after release.
REQ-038 Hold stability: tx_data_out is sampled every cycle while arb_busy = 1 -> no change observed.
